vram_shadow: RTL and testbench
==============================

# vram_shadow

Dual-port 32 KB screen-memory shadow sitting directly upstream of the video controller. It snoops CPU memory writes that land in RAM pages 5 and 7, plus an OSD loader write stream, into its own dual-port block RAM. It serves the controller's 15-bit `vram_addr` / 8-bit `vram_dout` fetch port with fixed single-clock latency. Video fetches never contend with CPU or loader writes.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: CPU write queue depth; power of two, 2..16.
- `CLEAR_ON_RESET`, 1: when 1, reset starts a full-RAM zero-fill.

Ports:
- `clk_sys  in  1`  master clock; all logic on posedge.
- `reset  in  1`  synchronous, active-high.
- `addr  in  16`  CPU address bus.
- `din  in  8`  CPU data out.
- `nMREQ  in  1`  CPU memory request, active low.
- `nWR  in  1`  CPU write strobe, active low.
- `nRFSH  in  1`  CPU refresh, active low.
- `m128  in  1`  1 = 128K paging active.
- `page_ram  in  3`  RAM page mapped at C000-FFFF.
- `ld_valid  in  1`  loader write request.
- `ld_ready  out  1`  loader write accepted this cycle when high with `ld_valid`.
- `ld_addr  in  15`  loader shadow address; bit 14 = 0 for page 5, 1 for page 7.
- `ld_data  in  8`  loader write data.
- `vram_addr  in  15`  video fetch address.
- `vram_dout  out  8`  video fetch data.
- `clear_busy  out  1`  zero-fill in progress.
- `ovf  out  1`  sticky: a CPU write was dropped because the FIFO was full.
- `fifo_level  out  5`  current CPU FIFO occupancy, 0..FIFO_DEPTH.

## Operation

- Storage: 32768 x 8 dual-port RAM.
  - Port A is write-only and shared by the sources below.
  - Port B is read-only and serves video.
- CPU snoop:
  - Define `wr_cyc = ~nMREQ & ~nWR & nRFSH`, registered once into `old_wr`.
  - A write event is the cycle where `wr_cyc & ~old_wr`.
  - `addr`/`din` are sampled in that same cycle.
- CPU address mapping (15-bit shadow address):
  - `addr[15:14]==01` -> `{0, addr[13:0]}` (page 5), in any mode.
  - `addr[15:14]==11 & m128 & page_ram==5` -> `{0, addr[13:0]}`.
  - `addr[15:14]==11 & m128 & page_ram==7` -> `{1, addr[13:0]}`.
  - Every other address, and any `addr[15:14]==11` write with `m128=0`, is ignored.
- CPU FIFO:
  - A mapped write event pushes `{addr15, data8}`.
  - If the FIFO is full, the entry is dropped and `ovf` is set; `ovf` clears only on reset.
- Port A arbiter, priority highest to lowest:
  - clear engine;
  - FIFO head (pop one per cycle);
  - loader.
- Loader handshake:
  - `ld_ready = ~clear_busy & fifo_empty`, combinational.
  - A transfer occurs when `ld_valid & ld_ready`; it writes `ld_data` to `ld_addr` that cycle.
  - The loader may hold `ld_valid` across stalls; `ld_addr`/`ld_data` must be stable while `ld_valid & ~ld_ready`.
- Clear engine:
  - Entered on reset release when `CLEAR_ON_RESET=1`.
  - 15-bit counter from 0 to 32767, writing 0x00 at one address per cycle.
  - `clear_busy` drops the cycle after address 32767 is written.
  - CPU writes arriving during the clear still queue. The FIFO drains only after the clear, so they are not lost unless the FIFO overflows.
- Video read:
  - `vram_addr` is registered into port B; `vram_dout` is RAM data.
  - While `clear_busy`, `vram_dout` is forced to 0x00.
  - Same-address read during a write returns the old data (read-first).

## Timing

- Reset values:
  - `vram_dout` = 0x00.
  - `ld_ready` = 0.
  - `clear_busy` = `CLEAR_ON_RESET`.
  - `ovf` = 0.
  - `fifo_level` = 0.
  - FIFO pointers and `old_wr` = 0.
- Video read latency is exactly 1 clk_sys: address at edge N gives data valid after edge N+1.
- CPU write latency, with the FIFO empty and no clear in progress:
  - the event is detected at edge N;
  - the entry is pushed at edge N;
  - the RAM is written at edge N+1;
  - readable on port B at N+2, with the output valid at N+3.
- A push and a pop in the same cycle leave `fifo_level` unchanged. A push into a full FIFO is rejected even if a pop occurs that cycle.
- A CPU write held low for many cycles produces exactly one event. A new event requires `wr_cyc` to deassert first.
- Full clear lasts 32768 cycles after reset release.
- Reset mid-operation:
  - the FIFO is flushed;
  - the clear restarts from address 0;
  - any loader beat not yet accepted is discarded; the loader must re-present it.
- Pointer arithmetic is modulo FIFO_DEPTH. `fifo_level` is the difference of (log2(FIFO_DEPTH)+1)-bit pointers.

## Test plan

- Reset with `CLEAR_ON_RESET=1`:
  - `clear_busy` is high for exactly 32768 cycles;
  - afterwards, reads of 0x0000, 0x3FFF and 0x7FFF return 0x00.
- CPU write 0x4000<=0xA5 with `m128=0`:
  - after 3 cycles, `vram_addr=0x0000` yields 0xA5;
  - a write to 0xC000 with `m128=0` leaves 0x4000 unchanged.
- `m128=1`, `page_ram=7`, CPU write 0xDAFF<=0x3C -> shadow 0x5AFF reads 0x3C.
- Same setup with `page_ram=5`, write to 0xC010 -> shadow 0x0010 is updated.
- During a clear, issue 5 CPU writes with `FIFO_DEPTH=4`:
  - `ovf` goes to 1 and `fifo_level` saturates at 4;
  - the first 4 writes appear after the clear ends; the 5th does not.
- Loader streams 6912 bytes to 0x0000..0x1AFF while CPU writes are interleaved:
  - `ld_ready` is low on every cycle with `fifo_level>0`;
  - the final contents match the bytes from whichever write reached RAM last;
  - no loader beat is lost across stalls.

Source files
------------

// File: rtl/vram_shadow.sv
// Dual-port 32 KB screen shadow: snoops CPU writes to RAM pages 5/7 and an OSD loader
// stream into a write-only port A, while port B serves video fetches.
module vram_shadow #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  din,
   input  logic        nMREQ,
   input  logic        nWR,
   input  logic        nRFSH,
   input  logic        m128,
   input  logic [2:0]  page_ram,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [14:0] ld_addr,
   input  logic [7:0]  ld_data,
   input  logic [14:0] vram_addr,
   output logic [7:0]  vram_dout,
   output logic        clear_busy,
   output logic        ovf,
   output logic [4:0]  fifo_level
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [14:0]   clr_cnt_q, clr_cnt_d;
   logic          old_wr_q, old_wr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic          blank_q, blank_d;
   logic [14:0]   raddr_q;
   logic [7:0]    rdata_q;

   logic [7:0]    ram      [0:32767];
   logic [22:0]   fifo_mem [0:FIFO_DEPTH-1];

   logic          wr_cyc, wr_evt, cpu_hit;
   logic [14:0]   cpu_saddr;
   logic [PW-1:0] level;
   logic          fifo_empty, fifo_full, push, pop, ld_fire;
   logic          we_a;
   logic [14:0]   wa_addr;
   logic [7:0]    wa_data;
   logic [22:0]   fifo_head;

   always_comb begin
      cpu_hit   = 1'b0;
      cpu_saddr = {1'b0, addr[13:0]};
      case (addr[15:14])
         2'b01: cpu_hit = 1'b1;
         2'b11: begin
            if (m128 && page_ram == 3'd5) begin
               cpu_hit = 1'b1;
            end else if (m128 && page_ram == 3'd7) begin
               cpu_hit      = 1'b1;
               cpu_saddr[14] = 1'b1;
            end
         end
         default: cpu_hit = 1'b0;
      endcase
   end

   assign clear_busy = (state_q == ST_CLEAR);
   assign wr_cyc     = ~nMREQ & ~nWR & nRFSH;
   assign wr_evt     = wr_cyc & ~old_wr_q;
   assign level      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == PW'(FIFO_DEPTH));
   // Fullness is judged before this cycle's pop, so a push into a full queue is dropped.
   assign push       = wr_evt & cpu_hit & ~fifo_full;
   assign pop        = ~clear_busy & ~fifo_empty;
   assign ld_ready   = ~reset & ~clear_busy & fifo_empty;
   assign ld_fire    = ld_valid & ld_ready;
   assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];
   assign fifo_level = 5'(level);
   assign ovf        = ovf_q;
   assign vram_dout  = (clear_busy | blank_q) ? '0 : rdata_q;

   always_comb begin
      we_a    = 1'b0;
      wa_addr = clr_cnt_q;
      wa_data = '0;
      if (!reset) begin
         if (clear_busy) begin
            we_a = 1'b1;
         end else if (pop) begin
            we_a    = 1'b1;
            wa_addr = fifo_head[22:8];
            wa_data = fifo_head[7:0];
         end else if (ld_fire) begin
            we_a    = 1'b1;
            wa_addr = ld_addr;
            wa_data = ld_data;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + 15'd1;
         if (clr_cnt_q == '1) state_d = ST_RUN;
      end
      old_wr_d = wr_cyc;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      ovf_d    = ovf_q | (wr_evt & cpu_hit & fifo_full);
      // Hold the output blank one extra cycle so a stale pre-clear read never leaks out.
      blank_d  = clear_busy;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_cnt_q <= '0;
         old_wr_q  <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         blank_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         old_wr_q  <= old_wr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
         blank_q   <= blank_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (we_a) ram[wa_addr] <= wa_data;
      raddr_q <= vram_addr;
      rdata_q <= ram[raddr_q];
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {cpu_saddr, din};
   end

endmodule

// File: tb/tb_vram_shadow.sv
// Randomized bench for vram_shadow: a queue/array model of the shadow is stepped every
// clock and checked against the DUT, with literal spot checks pinning the model.
module tb_vram_shadow;
   localparam int DEPTH = 4;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [15:0] addr;
   logic [7:0]  din;
   logic        nMREQ, nWR, nRFSH, m128;
   logic [2:0]  page_ram;
   logic        ld_valid, ld_ready;
   logic [14:0] ld_addr;
   logic [7:0]  ld_data;
   logic [14:0] vram_addr;
   logic [7:0]  vram_dout;
   logic        clear_busy, ovf;
   logic [4:0]  fifo_level;

   vram_shadow #(.FIFO_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
      .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din), .nMREQ(nMREQ), .nWR(nWR),
      .nRFSH(nRFSH), .m128(m128), .page_ram(page_ram), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .vram_addr(vram_addr),
      .vram_dout(vram_dout), .clear_busy(clear_busy), .ovf(ovf), .fifo_level(fifo_level)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int a; int d; } ent_t;
   ent_t       q[$];
   logic [7:0] mem_m [0:32767];
   bit         m_busy = 1'b1, m_ovf = 1'b0, m_oldwr = 1'b0, m_end = 1'b0, started = 1'b0;
   int         m_cnt = 0, m_raddr = 0, m_ld_cnt = 0;
   logic [7:0] m_dout = '0;

   function automatic bit map_cpu(input logic [15:0] a, input logic m, input logic [2:0] pg,
                                  output int sa);
      sa = int'(a[13:0]);
      if (a[15:14] == 2'b01) return 1'b1;
      if (a[15:14] == 2'b11 && m && pg == 3'd5) return 1'b1;
      if (a[15:14] == 2'b11 && m && pg == 3'd7) begin
         sa += 16384;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_step();
      bit   was_busy, rdy, wc, ev, full, hit;
      int   sa;
      ent_t e;
      was_busy = m_busy;
      m_dout   = mem_m[m_raddr];
      m_raddr  = int'(vram_addr);
      if (reset) begin
         m_busy  = 1'b1;
         m_cnt   = 0;
         q.delete();
         m_ovf   = 1'b0;
         m_oldwr = 1'b0;
         started = 1'b1;
      end else begin
         rdy     = !m_busy && q.size() == 0;
         wc      = !nMREQ && !nWR && nRFSH;
         ev      = wc && !m_oldwr;
         m_oldwr = wc;
         full    = q.size() == DEPTH;
         if (m_busy) begin
            mem_m[m_cnt] = 8'h00;
            if (m_cnt == 32767) m_busy = 1'b0;
            m_cnt++;
         end else if (q.size() > 0) begin
            e = q.pop_front();
            mem_m[e.a] = 8'(e.d);
         end else if (ld_valid && rdy) begin
            mem_m[int'(ld_addr)] = ld_data;
            m_ld_cnt++;
         end
         hit = map_cpu(addr, m128, page_ram, sa);
         if (ev && hit) begin
            if (full) m_ovf = 1'b1;
            else q.push_back('{a: sa, d: int'(din)});
         end
      end
      m_end = was_busy && !m_busy;
   endtask

   always @(posedge clk_sys) begin
      model_step();
      #1;
      if (started) begin
         chk("clear_busy", int'(clear_busy), int'(m_busy));
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("fifo_level", int'(fifo_level), q.size());
         chk("ld_ready", int'(ld_ready), int'(!reset && !m_busy && q.size() == 0));
         if (m_busy) chk("vram_dout_clear", int'(vram_dout), 0);
         else if (!m_end) chk("vram_dout", int'(vram_dout), int'(m_dout));
      end
   end

   // ---------------- stimulus ----------------
   bit counting = 1'b0;
   int busy_cnt = 0;

   task automatic tick();
      @(negedge clk_sys);
      if (counting && clear_busy) busy_cnt++;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
      tick(); tick();
      nMREQ = 1'b1; nWR = 1'b1;
      tick(); tick();
   endtask

   task automatic read_lit(input string name, input logic [14:0] a, input int exp);
      vram_addr = a;
      tick(); tick(); tick();
      chk(name, int'(vram_dout), exp);
   endtask

   initial begin
      int ld_idx, guard, cpu_cnt;
      bit acc;
      reset = 1'b1; addr = '0; din = '0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
      m128 = 1'b0; page_ram = 3'd0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      vram_addr = '0;
      tick(); tick(); tick();
      chk("rst_clear_busy", int'(clear_busy), 1);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_ld_ready", int'(ld_ready), 0);
      chk("rst_vram_dout", int'(vram_dout), 0);

      reset = 1'b0;
      counting = 1'b1;
      if (clear_busy) busy_cnt = 1;
      for (int i = 0; i < 5; i++) cpu_write(16'h4100 + 16'(i), 8'h11 + 8'(i));
      chk("clear_ovf", int'(ovf), 1);
      chk("clear_fifo_sat", int'(fifo_level), 4);
      guard = 0;
      while (clear_busy && guard < 40000) begin
         tick();
         guard++;
      end
      counting = 1'b0;
      chk("clear_len", busy_cnt, 32768);
      repeat (6) tick();

      read_lit("zero_0000", 15'h0000, 0);
      read_lit("zero_3fff", 15'h3FFF, 0);
      read_lit("zero_7fff", 15'h7FFF, 0);
      read_lit("q_0100", 15'h0100, 8'h11);
      read_lit("q_0103", 15'h0103, 8'h14);
      read_lit("dropped_0104", 15'h0104, 0);

      m128 = 1'b0;
      cpu_write(16'h4000, 8'hA5);
      read_lit("p5_4000", 15'h0000, 8'hA5);
      cpu_write(16'hC000, 8'h5A);
      read_lit("c000_m48", 15'h0000, 8'hA5);
      m128 = 1'b1; page_ram = 3'd7;
      cpu_write(16'hDAFF, 8'h3C);
      read_lit("p7_daff", 15'h5AFF, 8'h3C);
      page_ram = 3'd5;
      cpu_write(16'hC010, 8'h77);
      read_lit("p5_c010", 15'h0010, 8'h77);

      // A long strobe is one event: the data changed mid-strobe must not land.
      addr = 16'h4020; din = 8'h99; nMREQ = 1'b0; nWR = 1'b0;
      tick();
      din = 8'h42;
      repeat (5) tick();
      nMREQ = 1'b1; nWR = 1'b1;
      tick();
      read_lit("held_write", 15'h0020, 8'h99);

      m128 = 1'b0;
      ld_idx = 0; guard = 0; cpu_cnt = 0; acc = 1'b0;
      while (ld_idx < 6912 && guard < 40000) begin
         if (!ld_valid && $urandom_range(0, 3) != 0) begin
            ld_valid = 1'b1;
            ld_addr  = 15'(ld_idx);
            ld_data  = 8'($urandom);
         end
         if (cpu_cnt > 0) begin
            cpu_cnt--;
         end else if (!nMREQ) begin
            nMREQ = 1'b1; nWR = 1'b1; cpu_cnt = 1;
         end else if ($urandom_range(0, 5) == 0) begin
            addr = ($urandom_range(0, 7) == 0) ? 16'hC000 + 16'($urandom_range(0, 255))
                                               : 16'h4000 + 16'($urandom_range(0, 16'h1AFF));
            din = 8'($urandom);
            nMREQ = 1'b0; nWR = 1'b0; cpu_cnt = 2;
         end
         vram_addr = 15'($urandom);
         acc = ld_valid && ld_ready;
         tick();
         guard++;
         if (acc) begin
            ld_idx++;
            ld_valid = 1'b0;
         end
      end
      ld_valid = 1'b0; nMREQ = 1'b1; nWR = 1'b1;
      repeat (8) tick();
      chk("ld_stream_done", ld_idx, 6912);
      chk("ld_beats_model", m_ld_cnt, 6912);

      for (int i = 0; i < 6912; i++) begin
         vram_addr = 15'(i);
         tick();
      end
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
